uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter that answers the CPU's UART store and status-load strobes on the I/O side of the datapath. Bytes stored to the transmit-data address are queued in a small FIFO and serialized as 8N1 frames on `serial_out`. The transmit-ready status reported to the CPU is derived from this block's FIFO occupancy.

## Interface

Parameters:
- `CLOCK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bits per second.
- `FIFO_DEPTH`, default 4: transmit FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk`, input, 1 bit: the only clock. All state changes on its rising edge.
- `rst`, input, 1 bit: reset. Asynchronous, active-high.
- `we`, input, 1 bit: UART write strobe from control, single cycle per store.
- `re`, input, 1 bit: UART read strobe from control.
- `addr`, input, 32 bits: full byte address of the access.
- `wdata`, input, 32 bits: store data. Only bits [7:0] are used.
- `rdata`, output, 32 bits: load data. Combinational from registered state.
- `serial_out`, output, 1 bit: TX line. Idles high and is driven from a flop.

## Operation

- `CPB = CLOCK_FREQ / BAUD_RATE`, with integer truncation. CPB is the number of clock cycles per bit.
- The bit counter is wide enough to hold CPB − 1.

Address map (full 32-bit decode):
- `0x80000000`, read, status register:
  - bit0: `tx_ready`, which is `count < FIFO_DEPTH`.
  - bit1: `tx_idle`, which is FIFO empty and FSM in IDLE.
  - bit2: `overflow`, sticky.
  - bits [31:3]: 0.
- `0x80000008`, write: enqueue `wdata[7:0]`.
- Any other address:
  - A write has no effect.
  - A read returns 0.
- `rdata` is 0 whenever `re` is 0.

FIFO:
- Circular buffer with read pointer, write pointer and a `count` register.
- Pointers wrap modulo `FIFO_DEPTH`.
- Fullness is judged on the registered `count` at the start of the cycle. A write while `count == FIFO_DEPTH` is dropped and sets `overflow`, even if a pop occurs in the same cycle.
- A simultaneous push (not full) and pop leaves `count` unchanged.
- `overflow` clears on the rising edge that completes a status read (`re` and address `0x80000000`). If a dropped write coincides with that read, `overflow` stays set.

Transmit FSM (states IDLE, START, DATA, STOP). A cycle counter counts 0..CPB−1 within each bit; `bit_idx` counts 0..7.
- IDLE:
  - `serial_out` = 1.
  - If `count > 0`: pop the head into the shift register, set `serial_out` to 0, clear the cycle counter, go to START.
- START:
  - After CPB cycles, drive data bit 0 and go to DATA.
- DATA:
  - Drive the shift register LSB first, each bit for CPB cycles.
  - After bit 7 completes, drive 1 and go to STOP.
- STOP:
  - After CPB cycles, if `count > 0`: pop, drive 0, go to START. This gives back-to-back frames with no idle gap.
  - Otherwise go to IDLE.
- A frame is exactly 10·CPB cycles: 1 start bit, 8 data bits, 1 stop bit.

## Timing

- Reset values:
  - `serial_out` = 1.
  - FIFO empty (`count` = 0, both pointers = 0).
  - `overflow` = 0.
  - FSM in IDLE, counters 0.
  - `rdata` = 0.
  - Status after reset reads `0x00000003`.
- Reset mid-frame: `serial_out` returns to 1 immediately (asynchronously). The frame is aborted and queued bytes are discarded.
- Write latency: a write sampled at edge E with an empty FIFO and an idle FSM drives `serial_out` low from edge E+1. The pop happens at E+1.
- Status reflects a write from edge E onward. `tx_idle` falls at E and rises CPB cycles after the last stop bit begins, i.e. at the STOP → IDLE edge.
- `tx_ready` reflects `count` combinationally, so it is valid in the same cycle `re` is asserted.
- Capacity: one byte in the shifter plus `FIFO_DEPTH` queued. With defaults, 5 consecutive writes into an idle block are all accepted.

## Test plan

1. Reset, then read status → `rdata = 0x00000003`, `serial_out = 1`.
2. `CLOCK_FREQ=1000`, `BAUD_RATE=100` (CPB=10): write 0x55 at edge E → from E+1, `serial_out` is 0 for 10 cycles, then the bit sequence 1,0,1,0,1,0,1,0 at 10 cycles each, then 1 for 10 cycles. The whole frame spans exactly 100 cycles, and `tx_idle` returns to 1 at E+101.
3. CPB=10: write 0xA5 then 0x0F on consecutive cycles → two frames totalling 200 cycles. The second start bit begins on the cycle immediately after the first stop bit ends. Data LSB-first is 1,0,1,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
4. CPB=10, `FIFO_DEPTH=4`: 6 consecutive writes 0x01..0x06 → the first 5 are transmitted in order and 0x06 is never sent. After the 6th write, status reads `0x00000004`. A second status read returns bit2 = 0.
5. CPB=10: write 0xFF, assert `rst` 35 cycles into the frame → `serial_out` is 1 immediately. After deassertion, status is `0x00000003` and there is no further line activity.
6. Read and write to address `0x80000004`, and write to `0x80000000` → `rdata = 0`, FIFO `count` unchanged, `serial_out` stays 1.

Source files
------------

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_mmio : memory-mapped 8N1 UART transmitter with a transmit FIFO   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_tx_mmio #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic        re,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        serial_out
);

   localparam int CPB   = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [31:0]      STAT_ADDR = 32'h8000_0000;
   localparam logic [31:0]      TX_ADDR   = 32'h8000_0008;
   localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(CPB - 1);
   localparam logic [CNT_W-1:0] CYC_ONE   = CNT_W'(1);
   localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cyc;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             overflow;

   logic wr_hit, full, push, drop, stat_rd, pop, bit_end, unused_wdata;

   assign wr_hit       = we && (addr == TX_ADDR);
   assign full         = (count == CNT_FULL);
   assign push         = wr_hit && !full;
   assign drop         = wr_hit && full;
   assign stat_rd      = re && (addr == STAT_ADDR);
   assign bit_end      = (cyc == CYC_LAST);
   assign unused_wdata = ^wdata[31:8];

   // The FSM takes the head either from IDLE or at the tail of a stop bit,
   // which is what gives back-to-back frames without a gap.
   assign pop = (count != '0) && ((state == IDLE) || ((state == STOP) && bit_end));

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata[7:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end else if (stat_rd) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cyc        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         serial_out <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               serial_out <= 1'b1;
               cyc        <= '0;
               if (pop) begin
                  shift      <= mem[rd_ptr];
                  serial_out <= 1'b0;
                  state      <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  cyc        <= '0;
                  bit_idx    <= '0;
                  serial_out <= shift[0];
                  state      <= DATA;
               end else begin
                  cyc <= cyc + CYC_ONE;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cyc <= '0;
                  if (bit_idx == 3'd7) begin
                     serial_out <= 1'b1;
                     state      <= STOP;
                  end else begin
                     bit_idx    <= bit_idx + 3'd1;
                     serial_out <= shift[1];
                     shift      <= {1'b0, shift[7:1]};
                  end
               end else begin
                  cyc <= cyc + CYC_ONE;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cyc <= '0;
                  if (pop) begin
                     shift      <= mem[rd_ptr];
                     serial_out <= 1'b0;
                     state      <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cyc <= cyc + CYC_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      if (stat_rd) begin
         rdata = {29'd0, overflow, ((count == '0) && (state == IDLE)), !full};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_mmio : self-checking bench with a line-decoding reference     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_uart_tx_mmio;

   localparam int CLOCK_FREQ = 1000;
   localparam int BAUD_RATE  = 100;
   localparam int FIFO_DEPTH = 4;
   localparam int CPB        = CLOCK_FREQ / BAUD_RATE;
   localparam int FRAME      = 10 * CPB;

   localparam logic [31:0] STAT_ADDR = 32'h8000_0000;
   localparam logic [31:0] TX_ADDR   = 32'h8000_0008;
   localparam logic [31:0] BAD_ADDR  = 32'h8000_0004;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        serial_out;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] exp_q[$];
   logic       mon_en = 1'b0;
   logic [7:0] mon_byte;

   uart_tx_mmio #(
      .CLOCK_FREQ (CLOCK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .we         (we),
      .re         (re),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .serial_out (serial_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Ideal 8N1 waveform: cycle j after the first start bit begins.
   function automatic logic exp_line(input logic [7:0] b0, input logic [7:0] b1, input int j);
      logic [7:0] b;
      int p;
      b = (j >= FRAME) ? b1 : b0;
      p = j % FRAME;
      if (p < CPB) return 1'b0;
      if (p >= 9 * CPB) return 1'b1;
      return b[(p - CPB) / CPB];
   endfunction

   // Line monitor: decodes frames at bit centres and matches them in order.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && !rst && serial_out == 1'b0) begin
            repeat (CPB / 2 - 1) @(negedge clk);
            check("mon_start", serial_out, 0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               mon_byte[i] = serial_out;
            end
            repeat (CPB) @(negedge clk);
            check("mon_stop", serial_out, 1);
            if (exp_q.size() == 0) check("mon_unexpected_frame", {24'd0, mon_byte}, 32'h100);
            else                   check("mon_frame", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
            repeat (CPB / 2) @(negedge clk);
         end
      end
   end

   task automatic rd_stat(input string tag, input logic [31:0] exp);
      @(negedge clk);
      re   = 1'b1;
      addr = STAT_ADDR;
      #1 check(tag, rdata, exp);
      @(negedge clk);
      re   = 1'b0;
      addr = '0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] d);
      @(negedge clk);
      we    = 1'b1;
      addr  = a;
      wdata = {$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), d};
   endtask

   // Caller sits on the negedge right after the first start bit began.
   task automatic expect_frames(input logic [7:0] b0, input logic [7:0] b1, input int nfr);
      re = 1'b0;
      for (int j = 0; j < nfr * FRAME; j++) begin
         if (j > 0) @(negedge clk);
         check("line", serial_out, exp_line(b0, b1, j));
      end
      re   = 1'b1;
      addr = STAT_ADDR;
      #1 check("idle_still_low", rdata, 32'h1);
      @(negedge clk);
      #1 check("idle_rises", rdata, 32'h3);
      re = 1'b0;
   endtask

   task automatic drain;
      for (int t = 0; t < 40 * FRAME && exp_q.size() != 0; t++) @(negedge clk);
      check("drain_left", exp_q.size(), 0);
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic quiet(input string tag, input int cycles);
      int lows;
      lows = 0;
      for (int t = 0; t < cycles; t++) begin
         @(negedge clk);
         if (serial_out !== 1'b1) lows++;
      end
      check(tag, lows, 0);
   endtask

   initial begin
      int offs[2];
      int len;
      logic [7:0] b;
      logic [31:0] ra;
      offs[0] = 5;
      offs[1] = 35;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      addr = STAT_ADDR;
      #1 check("rdata_no_re", rdata, 0);
      check("reset_line", serial_out, 1);
      rd_stat("reset_status", 32'h3);
      mon_en = 1'b1;

      // single frame with exact bit timing
      wr(TX_ADDR, 8'h55);
      exp_q.push_back(8'h55);
      @(negedge clk);
      we = 1'b0; addr = STAT_ADDR; re = 1'b1;
      #1 check("status_after_wr", rdata, 32'h1);
      check("line_before_e1", serial_out, 1);
      @(negedge clk);
      expect_frames(8'h55, 8'h00, 1);
      drain();

      // back-to-back frames
      wr(TX_ADDR, 8'hA5);
      exp_q.push_back(8'hA5);
      wr(TX_ADDR, 8'h0F);
      exp_q.push_back(8'h0F);
      @(negedge clk);
      we = 1'b0;
      expect_frames(8'hA5, 8'h0F, 2);
      drain();

      // overflow on the sixth consecutive write
      for (int k = 1; k <= 6; k++) begin
         wr(TX_ADDR, 8'(k));
         if (k <= 5) exp_q.push_back(8'(k));
      end
      @(negedge clk);
      we = 1'b0;
      re = 1'b1; addr = STAT_ADDR;
      #1 check("overflow_status", rdata, 32'h4);
      @(negedge clk);
      #1 check("overflow_cleared", rdata & 32'h4, 0);
      re = 1'b0;
      drain();
      rd_stat("after_overflow_drain", 32'h3);

      // reset mid-frame
      mon_en = 1'b0;
      foreach (offs[k]) begin
         wr(TX_ADDR, 8'hFF);
         @(negedge clk);
         we = 1'b0;
         @(negedge clk);
         repeat (offs[k]) @(negedge clk);
         check("pre_reset_line", serial_out, exp_line(8'hFF, 8'h00, offs[k]));
         rst = 1'b1;
         #1 check("reset_async_line", serial_out, 1);
         repeat (2) @(negedge clk);
         rst = 1'b0;
         rd_stat("post_reset_status", 32'h3);
         quiet("post_reset_quiet", 15 * CPB);
      end
      mon_en = 1'b1;

      // unmapped and read-only addresses
      @(negedge clk);
      re = 1'b1; addr = BAD_ADDR;
      #1 check("bad_addr_read", rdata, 0);
      re = 1'b0;
      wr(BAD_ADDR, 8'h3C);
      wr(STAT_ADDR, 8'hC3);
      @(negedge clk);
      we = 1'b0;
      rd_stat("bad_write_status", 32'h3);
      quiet("bad_write_quiet", 12 * CPB);

      // randomized bursts against the queue model
      for (int it = 0; it < 20; it++) begin
         len = $urandom_range(1, 8);
         for (int k = 0; k < len; k++) begin
            if (len <= 5 && k > 0) begin
               repeat ($urandom_range(0, 15)) begin
                  @(negedge clk);
                  we = 1'b0;
                  ra = $urandom();
                  if (ra == STAT_ADDR || ra == TX_ADDR) ra = BAD_ADDR;
                  re = 1'b1; addr = ra;
                  #1 check("rand_bad_read", rdata, 0);
                  re = 1'b0;
               end
            end
            b = 8'($urandom_range(0, 255));
            wr(TX_ADDR, b);
            if (k < 5) exp_q.push_back(b);
         end
         @(negedge clk);
         we = 1'b0;
         drain();
         rd_stat("rand_status", (len > 5) ? 32'h7 : 32'h3);
      end

      check("model_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #800_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
